memory_loader: RTL and testbench

Parametrised successor to the board-level memory programmer for the CDEC8 FPGA shell. It turns a raw step push-button, a 2-bit command and the data slide switches into single-cycle accesses on the program RAM port: write, read-back, address load and whole-memory fill. It adds debouncing, address auto-increment with a wrap flag, and a busy indication. It sits between the board I/O and the RAM address/data mux that is selected in program mode.

---
 rtl/memory_loader.sv | 175 +++++++++++++++++
 tb/tb_memory_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_loader.sv
// Board-side programmer for the program RAM: debounced step button plus 2-bit command
// drive single-cycle write, read-back, address load and whole-memory fill accesses.
module memory_loader #(
  parameter int                ADRS_W     = 8,
  parameter int                DATA_W     = 8,
  parameter int                DEB_CYCLES = 4,
  parameter logic [DATA_W-1:0] FILL_VAL   = '0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_step_btn,
  input  logic [1:0]        i_cmd,
  input  logic [DATA_W-1:0] i_sw_data,
  input  logic [DATA_W-1:0] i_mm_q,
  output logic [ADRS_W-1:0] o_mm_adrs,
  output logic [DATA_W-1:0] o_mm_data,
  output logic              o_mm_wr_en,
  output logic              o_busy,
  output logic [ADRS_W-1:0] o_cur_adrs,
  output logic [DATA_W-1:0] o_cur_data,
  output logic              o_wrapped
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_FILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ_WAIT,
    S_READ_CAP,
    S_FILL
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic             r_stable;
  logic [CNT_W-1:0] r_deb_cnt;
  logic             r_press;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ADRS_W-1:0] r_cur_adrs;
  logic [DATA_W-1:0] r_cur_data;
  logic              r_wrapped;
  logic [ADRS_W-1:0] r_fill_cnt;

  logic [ADRS_W-1:0] w_adrs_inc;
  logic [ADRS_W-1:0] w_load_adrs;
  logic              w_adrs_max;
  logic              w_fill_last;

  assign w_adrs_inc  = r_cur_adrs + ADRS_W'(1);
  assign w_load_adrs = ADRS_W'(i_sw_data);
  assign w_adrs_max  = (r_cur_adrs == '1);
  assign w_fill_last = (r_fill_cnt == '1);

  // Stable level only moves after DEB_CYCLES consecutive disagreeing samples;
  // the press pulse is registered so it is high the cycle after the rise is accepted.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_stable  <= 1'b0;
      r_deb_cnt <= '0;
      r_press   <= 1'b0;
    end else begin
      r_s1    <= i_step_btn;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_s2 != r_stable) begin
        if (r_deb_cnt == DEB_LAST) begin
          r_stable  <= r_s2;
          r_deb_cnt <= '0;
          r_press   <= r_s2;
        end else begin
          r_deb_cnt <= r_deb_cnt + CNT_W'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_press) begin
          case (i_cmd)
            CMD_WRITE: w_state_nxt = S_WRITE;
            CMD_READ:  w_state_nxt = S_READ_WAIT;
            CMD_FILL:  w_state_nxt = S_FILL;
            default:   w_state_nxt = S_IDLE;
          endcase
        end
      end
      S_WRITE:     w_state_nxt = S_IDLE;
      S_READ_WAIT: w_state_nxt = S_READ_CAP;
      S_READ_CAP:  w_state_nxt = S_IDLE;
      S_FILL:      if (w_fill_last) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // RAM port is decoded from registered state only; sw_data is the sole pass-through.
  always_comb begin
    o_mm_adrs  = r_cur_adrs;
    o_mm_data  = '0;
    o_mm_wr_en = 1'b0;
    case (r_state)
      S_IDLE:  o_mm_data = i_sw_data;
      S_WRITE: begin
        o_mm_data  = i_sw_data;
        o_mm_wr_en = 1'b1;
      end
      S_FILL: begin
        o_mm_adrs  = r_fill_cnt;
        o_mm_data  = FILL_VAL;
        o_mm_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cur_adrs <= '0;
      r_cur_data <= '0;
      r_wrapped  <= 1'b0;
      r_fill_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (r_press && i_cmd == CMD_LOAD) begin
            r_cur_adrs <= w_load_adrs;
            r_wrapped  <= 1'b0;
          end
          if (r_press && i_cmd == CMD_FILL) r_fill_cnt <= '0;
        end
        S_WRITE: begin
          r_cur_data <= i_sw_data;
          r_cur_adrs <= w_adrs_inc;
          if (w_adrs_max) r_wrapped <= 1'b1;
        end
        S_READ_CAP: begin
          r_cur_data <= i_mm_q;
          r_cur_adrs <= w_adrs_inc;
          if (w_adrs_max) r_wrapped <= 1'b1;
        end
        S_FILL: begin
          r_fill_cnt <= r_fill_cnt + ADRS_W'(1);
          if (w_fill_last) begin
            r_cur_adrs <= '0;
            r_wrapped  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state != S_IDLE);
  assign o_cur_adrs = r_cur_adrs;
  assign o_cur_data = r_cur_data;
  assign o_wrapped  = r_wrapped;

endmodule

// File: tb/tb_memory_loader.sv
// Directed and randomized bench for memory_loader with a behavioural RAM and reference model.
module tb_memory_loader;

  localparam int         AW  = 8;
  localparam int         DW  = 8;
  localparam int         DEB = 4;
  localparam logic [7:0] FV  = 8'hEE;

  logic          clk;
  logic          rst;
  logic          btn;
  logic [1:0]    cmd;
  logic [DW-1:0] sw;
  logic [DW-1:0] mm_q;
  logic [AW-1:0] mm_adrs;
  logic [DW-1:0] mm_data;
  logic          mm_wr_en;
  logic          busy;
  logic [AW-1:0] cur_adrs;
  logic [DW-1:0] cur_data;
  logic          wrapped;

  memory_loader #(
    .ADRS_W(AW), .DATA_W(DW), .DEB_CYCLES(DEB), .FILL_VAL(FV)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_step_btn(btn), .i_cmd(cmd),
    .i_sw_data(sw), .i_mm_q(mm_q), .o_mm_adrs(mm_adrs), .o_mm_data(mm_data),
    .o_mm_wr_en(mm_wr_en), .o_busy(busy), .o_cur_adrs(cur_adrs),
    .o_cur_data(cur_data), .o_wrapped(wrapped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (mm_wr_en) ram[mm_adrs] <= mm_data;
    mm_q <= ram[mm_adrs];
  end

  // Reference model: architectural view of the loader plus the RAM contents it implies.
  logic [7:0] m_adrs;
  logic [7:0] m_data;
  logic       m_wrap;
  logic [7:0] m_mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic do_op(input logic [1:0] c, input logic [7:0] d, input bit glitch, input string tag);
    int hold, nwr, nbusy, exp_wr, exp_busy;
    logic [7:0] a0;
    if (glitch) begin
      btn = 1'b1;
      repeat ($urandom_range(1, DEB - 1)) @(negedge clk);
      btn = 1'b0;
      repeat (4) @(negedge clk);
    end
    cmd = c; sw = d; btn = 1'b1;
    hold = $urandom_range(6, 12);
    nwr = 0; nbusy = 0;
    for (int k = 0; k < hold + 14; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == hold - 1) btn = 1'b0;
      if (mm_wr_en) nwr++;
      if (busy) nbusy++;
    end
    a0 = m_adrs;
    exp_wr = 0; exp_busy = 0;
    case (c)
      2'b01: begin
        m_mem[a0] = d; m_data = d; m_adrs = a0 + 8'd1;
        if (a0 == 8'hFF) m_wrap = 1'b1;
        exp_wr = 1; exp_busy = 1;
      end
      2'b00: begin
        m_data = m_mem[a0]; m_adrs = a0 + 8'd1;
        if (a0 == 8'hFF) m_wrap = 1'b1;
        exp_busy = 2;
      end
      default: begin
        m_adrs = d; m_wrap = 1'b0;
      end
    endcase
    chk({tag, " wr_cycles"}, 32'(nwr), 32'(exp_wr));
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'(exp_busy));
    chk({tag, " cur_adrs"}, 32'(cur_adrs), 32'(m_adrs));
    chk({tag, " cur_data"}, 32'(cur_data), 32'(m_data));
    chk({tag, " wrapped"}, 32'(wrapped), 32'(m_wrap));
    if (c == 2'b01) chk({tag, " ram"}, 32'(ram[a0]), 32'(m_mem[a0]));
  endtask

  initial begin
    int nwr, nbusy, first, bad, ph;
    logic [7:0] lasta;
    rst = 1'b1; btn = 1'b0; cmd = 2'b00; sw = '0;
    m_adrs = '0; m_data = '0; m_wrap = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset mm_wr_en", 32'(mm_wr_en), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset mm_adrs", 32'(mm_adrs), 32'd0);
    chk("reset mm_data", 32'(mm_data), 32'd0);
    chk("reset cur_adrs", 32'(cur_adrs), 32'd0);
    chk("reset cur_data", 32'(cur_data), 32'd0);
    chk("reset wrapped", 32'(wrapped), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Short glitch must be swallowed.
    cmd = 2'b01; sw = 8'h99; btn = 1'b1;
    nwr = 0; nbusy = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == DEB - 2) btn = 1'b0;
      if (mm_wr_en) nwr++;
      if (busy) nbusy++;
    end
    chk("glitch wr_cycles", 32'(nwr), 32'd0);
    chk("glitch busy_cycles", 32'(nbusy), 32'd0);

    // Long hold: one write, starting at edge 2+DEB after the first sample.
    cmd = 2'b01; sw = 8'h42; btn = 1'b1;
    nwr = 0; first = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 19) btn = 1'b0;
      if (mm_wr_en) begin
        nwr++;
        if (first < 0) first = k;
      end
    end
    m_mem[0] = 8'h42; m_data = 8'h42; m_adrs = 8'd1;
    chk("hold wr_cycles", 32'(nwr), 32'd1);
    chk("hold first_wr_edge", 32'(first), 32'(2 + DEB));
    chk("hold ram0", 32'(ram[0]), 32'h42);
    chk("hold cur_adrs", 32'(cur_adrs), 32'(m_adrs));

    do_op(2'b10, 8'h10, 1'b0, "load10");
    do_op(2'b01, 8'hA5, 1'b0, "wrA5");
    do_op(2'b01, 8'h3C, 1'b1, "wr3C");
    do_op(2'b10, 8'h10, 1'b0, "reload10");
    do_op(2'b00, 8'h00, 1'b0, "rd10");
    chk("rd10 value", 32'(cur_data), 32'hA5);
    do_op(2'b00, 8'h00, 1'b1, "rd11");
    chk("rd11 value", 32'(cur_data), 32'h3C);
    chk("rd cur_adrs", 32'(cur_adrs), 32'h12);
    do_op(2'b10, 8'hFF, 1'b0, "loadFF");
    do_op(2'b01, 8'h77, 1'b0, "wrFF");
    chk("wrap set", 32'(wrapped), 32'd1);
    do_op(2'b10, 8'h05, 1'b0, "load05");
    chk("wrap cleared", 32'(wrapped), 32'd0);

    // Full fill with an ignored press in the middle.
    cmd = 2'b11; sw = 8'h5A; btn = 1'b1;
    nwr = 0; nbusy = 0; first = -1; bad = 0;
    for (int k = 0; k < 320; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 7) btn = 1'b0;
      if (k == 50) begin cmd = 2'b01; sw = 8'h99; btn = 1'b1; end
      if (k == 60) btn = 1'b0;
      if (busy) nbusy++;
      if (mm_wr_en) begin
        if (first < 0) first = k;
        if (mm_adrs !== 8'(nwr) || mm_data !== FV || k != first + nwr) bad++;
        nwr++;
      end
    end
    for (int i = 0; i < 256; i++) m_mem[i] = FV;
    m_adrs = '0; m_wrap = 1'b0;
    chk("fill wr_cycles", 32'(nwr), 32'd256);
    chk("fill busy_cycles", 32'(nbusy), 32'd256);
    chk("fill first_edge", 32'(first), 32'(2 + DEB));
    chk("fill sequence_errors", 32'(bad), 32'd0);
    chk("fill cur_adrs", 32'(cur_adrs), 32'd0);
    chk("fill cur_data", 32'(cur_data), 32'(m_data));
    chk("fill wrapped", 32'(wrapped), 32'd0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== FV) bad++;
    chk("fill ram_errors", 32'(bad), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] c;
      c = 2'($urandom_range(0, 2));
      do_op(c, 8'($urandom), 1'($urandom_range(0, 1)), "rnd");
    end

    // Reset in the middle of a fill.
    do_op(2'b10, 8'h33, 1'b0, "load33");
    cmd = 2'b11; sw = 8'h00; btn = 1'b1;
    nwr = 0; ph = 0; lasta = '0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 7) btn = 1'b0;
      if (ph == 1) begin
        chk("rstfill mm_wr_en", 32'(mm_wr_en), 32'd0);
        chk("rstfill busy", 32'(busy), 32'd0);
        chk("rstfill mm_adrs", 32'(mm_adrs), 32'd0);
        chk("rstfill mm_data", 32'(mm_data), 32'd0);
        chk("rstfill cur_adrs", 32'(cur_adrs), 32'd0);
        chk("rstfill cur_data", 32'(cur_data), 32'd0);
        chk("rstfill wrapped", 32'(wrapped), 32'd0);
        rst = 1'b0;
        ph = 2;
      end else if (mm_wr_en) begin
        nwr++;
        lasta = mm_adrs;
        if (ph == 0 && mm_adrs == 8'd4) begin rst = 1'b1; ph = 1; end
      end
    end
    rst = 1'b0;
    chk("rstfill reached", 32'(ph), 32'd2);
    chk("rstfill writes", 32'(nwr), 32'd5);
    chk("rstfill last_adrs", 32'(lasta), 32'd4);
    for (int i = 0; i < 5; i++) m_mem[i] = FV;
    m_adrs = '0; m_data = '0; m_wrap = 1'b0;
    bad = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== m_mem[i]) bad++;
    chk("rstfill ram_errors", 32'(bad), 32'd0);
    do_op(2'b01, 8'h5C, 1'b0, "postrst_wr");
    do_op(2'b10, 8'h00, 1'b0, "postrst_load");
    do_op(2'b00, 8'h00, 1'b0, "postrst_rd");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
